// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the uart transmitter: first-word-fall-through head on txdin/txgo, pop on txgo & txrdy.
// Optional sticky overflow flag enabled by defining UART_TXFIFO_OVF_EN.
module uart_tx_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          flush,
    input  logic          ovf_clr,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic [7:0]    txdin,
    output logic          txgo,
    input  logic          txrdy
);

    localparam int unsigned DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, mem_we, ovf_event;

    always_comb begin
        full      = (count_q == FULL_CNT);
        empty     = (count_q == '0);
        level     = count_q;
        txgo      = ~empty;
        txdin     = mem_q[rd_ptr_q];
        push      = wr_en & ~full;
        pop       = txgo & txrdy;
        ovf_event = wr_en & full & ~flush;

        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        count_d   = count_q;
        mem_we    = 1'b0;

        // A pop coinciding with flush still hands its byte to the uart; the FIFO just empties.
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

`ifdef UART_TXFIFO_OVF_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr) begin
            ovf_d = 1'b0;
        end
        if (ovf_event) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_ovf;
    assign unused_ovf = ovf_clr ^ ovf_event;
    assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo (AW=4); txrdy is driven directly as the uart accept.
// Expected ovf follows UART_TXFIFO_OVF_EN.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       flush;
    logic       ovf_clr;
    logic       full;
    logic       empty;
    logic [4:0] level;
    logic       ovf;
    logic [7:0] txdin;
    logic       txgo;
    logic       txrdy;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

`ifdef UART_TXFIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    uart_tx_fifo #(.AW(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .flush   (flush),
        .ovf_clr (ovf_clr),
        .full    (full),
        .empty   (empty),
        .level   (level),
        .ovf     (ovf),
        .txdin   (txdin),
        .txgo    (txgo),
        .txrdy   (txrdy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    // One uart accept followed by idle cycles standing in for the frame.
    task automatic pop_frame(input int unsigned idle);
        txrdy = 1'b1;
        tick();
        txrdy = 1'b0;
        for (int unsigned i = 0; i < idle; i++) tick();
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0; ovf_clr = 1'b0; txrdy = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_empty", 32'(empty), 1);
        check("rst_full",  32'(full),  0);
        check("rst_level", 32'(level), 0);
        check("rst_txgo",  32'(txgo),  0);
        check("rst_ovf",   32'(ovf),   0);

        // Single byte, one-cycle latency to txdin/txgo, then accept.
        push(8'h55);
        check("t1_txgo",  32'(txgo),  1);
        check("t1_txdin", 32'(txdin), 32'h55);
        check("t1_level", 32'(level), 1);
        pop_frame(3);
        check("t1_level_after", 32'(level), 0);
        check("t1_empty_after", 32'(empty), 1);

        // Back-to-back burst drains in order.
        push(8'h41); push(8'h42); push(8'h43);
        check("t2_level", 32'(level), 3);
        check("t2_head_a", 32'(txdin), 32'h41);
        pop_frame(4);
        check("t2_head_b", 32'(txdin), 32'h42);
        check("t2_level_b", 32'(level), 2);
        pop_frame(4);
        check("t2_head_c", 32'(txdin), 32'h43);
        pop_frame(4);
        check("t2_empty", 32'(empty), 1);
        check("t2_txgo",  32'(txgo),  0);

        // Fill to full with no accepts; 17th byte dropped.
        for (int unsigned i = 0; i < 16; i++) push(8'(i));
        check("t3_full",  32'(full),  1);
        check("t3_level", 32'(level), 16);
        check("t3_ovf_pre", 32'(ovf), 0);
        push(8'h10);
        check("t3_level_drop", 32'(level), 16);
        check("t3_head", 32'(txdin), 32'h00);
        check("t3_ovf", 32'(ovf), 32'(OVF_EXP));

        // Full + wr_en + pop: byte still dropped, one pop happens.
        wr_en = 1'b1; wr_data = 8'hAA; txrdy = 1'b1;
        tick();
        wr_en = 1'b0; txrdy = 1'b0;
        check("t3_fullpop_level", 32'(level), 15);
        check("t3_fullpop_head",  32'(txdin), 32'h01);
        push(8'h20);
        check("t3_refill_full", 32'(full), 1);

        // Overflow set and clear in the same cycle: set wins; then clear alone.
        wr_en = 1'b1; wr_data = 8'hBB; ovf_clr = 1'b1;
        tick();
        wr_en = 1'b0;
        check("t4_set_wins", 32'(ovf), 32'(OVF_EXP));
        tick();
        ovf_clr = 1'b0;
        check("t4_cleared", 32'(ovf), 0);

        // Drain: contents 0x01..0x0F then 0x20 (written after wr_ptr wrapped).
        for (int unsigned i = 1; i < 16; i++) begin
            check("t4_drain", 32'(txdin), i);
            pop_frame(1);
        end
        check("t4_drain_last", 32'(txdin), 32'h20);
        pop_frame(1);
        check("t4_drained_empty", 32'(empty), 1);

        // Queue five, accept two, flush mid second frame.
        for (int unsigned i = 0; i < 5; i++) push(8'h61 + 8'(i));
        pop_frame(2);
        check("t5_head2", 32'(txdin), 32'h62);
        pop_frame(2);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("t5_level", 32'(level), 0);
        check("t5_txgo",  32'(txgo),  0);
        tick(); tick();
        check("t5_still_empty", 32'(empty), 1);

        // Flush with concurrent push and pop: all discarded, no overflow.
        push(8'h71); push(8'h72);
        flush = 1'b1; wr_en = 1'b1; wr_data = 8'h73; txrdy = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0; txrdy = 1'b0;
        check("t5_flush_push_level", 32'(level), 0);
        for (int unsigned i = 0; i < 16; i++) push(8'h80 + 8'(i));
        flush = 1'b1; wr_en = 1'b1;
        tick();
        flush = 1'b0; wr_en = 1'b0;
        check("t5_flush_full_level", 32'(level), 0);
        check("t5_flush_no_ovf", 32'(ovf), 0);

        // Push and pop in the same cycle at level 3.
        push(8'h91); push(8'h92); push(8'h93);
        wr_en = 1'b1; wr_data = 8'h94; txrdy = 1'b1;
        tick();
        wr_en = 1'b0; txrdy = 1'b0;
        check("t6_level_same", 32'(level), 3);
        check("t6_head", 32'(txdin), 32'h92);

        // Fill, overflow, then reset mid-burst.
        for (int unsigned i = 0; i < 13; i++) push(8'hC0 + 8'(i));
        check("t6_full", 32'(full), 1);
        push(8'hFF);
        check("t6_ovf", 32'(ovf), 32'(OVF_EXP));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rst_level", 32'(level), 0);
        check("t6_rst_txgo",  32'(txgo),  0);
        check("t6_rst_ovf",   32'(ovf),   0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
